// File: rtl/diagnosis_stackargs_snapshot_pkg.sv
// Shared types for the stack-argument snapshot unit: flit type codes, l.sw opcode,
// event-queue entry layout and the read FSM state encoding.
package diagnosis_stackargs_snapshot_pkg;

    typedef enum logic [2:0] {
        SNAPSHOT_FLIT_TYPE_NONE   = 3'd0,
        SNAPSHOT_FLIT_TYPE_FIRST  = 3'd1,
        SNAPSHOT_FLIT_TYPE_MIDDLE = 3'd2,
        SNAPSHOT_FLIT_TYPE_LAST   = 3'd3,
        SNAPSHOT_FLIT_TYPE_SINGLE = 3'd4
    } flit_type_e;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} rd_state_e;

    localparam logic [5:0] OPC_LSW = 6'b110101;

    // One event-queue entry; drop marks an event that found every set busy.
    typedef struct packed {
        logic       drop;
        logic [5:0] n;
    } evt_t;

    function automatic flit_type_e flit_type(input logic [5:0] cnt, input logic [5:0] idx);
        if (cnt == 6'd0)              return SNAPSHOT_FLIT_TYPE_NONE;
        if (cnt == 6'd1)              return SNAPSHOT_FLIT_TYPE_SINGLE;
        if (idx == 6'd0)              return SNAPSHOT_FLIT_TYPE_FIRST;
        if (idx == cnt - 6'd1)        return SNAPSHOT_FLIT_TYPE_LAST;
        return SNAPSHOT_FLIT_TYPE_MIDDLE;
    endfunction

endpackage

// File: rtl/diagnosis_stackargs_snapshot_if.sv
// Trace, GPR, event and flit-stream signals of the snapshot unit.
// DIAGNOSIS_STACKARGS_DROPCNT_EN adds the drop counter output.
interface diagnosis_stackargs_snapshot_if #(parameter int DATA_WIDTH = 32);
    import diagnosis_stackargs_snapshot_pkg::*;

    logic [31:0]           trace_insn;
    logic                  trace_enable;
    logic [4:0]            gpr_addr_o;
    logic [DATA_WIDTH-1:0] gpr_data_i;
    logic [5:0]            args_in;
    logic                  args_valid;
    logic                  args_ready;
    logic [DATA_WIDTH-1:0] out_data;
    flit_type_e            out_type;
    logic                  out_valid;
    logic                  out_ready;
`ifdef DIAGNOSIS_STACKARGS_DROPCNT_EN
    logic [15:0]           drop_cnt_o;

    modport master (output trace_insn, trace_enable, gpr_data_i, args_in, args_valid, out_ready,
                    input  gpr_addr_o, args_ready, out_data, out_type, out_valid, drop_cnt_o);
    modport slave  (input  trace_insn, trace_enable, gpr_data_i, args_in, args_valid, out_ready,
                    output gpr_addr_o, args_ready, out_data, out_type, out_valid, drop_cnt_o);
`else
    modport master (output trace_insn, trace_enable, gpr_data_i, args_in, args_valid, out_ready,
                    input  gpr_addr_o, args_ready, out_data, out_type, out_valid);
    modport slave  (input  trace_insn, trace_enable, gpr_data_i, args_in, args_valid, out_ready,
                    output gpr_addr_o, args_ready, out_data, out_type, out_valid);
`endif

endinterface

// File: rtl/diagnosis_stackargs_setbuf.sv
// SETS x ARGS_MAX snapshot storage: whole-set copy from the live buffer and a
// combinational (set, idx) read mux.
module diagnosis_stackargs_setbuf #(
    parameter int DATA_WIDTH = 32,
    parameter int ARGS_MAX   = 8,
    parameter int SETS       = 4,
    localparam int SW = $clog2(SETS),
    localparam int IW = (ARGS_MAX > 1) ? $clog2(ARGS_MAX) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               copy_en,
    input  logic [SW-1:0]                      copy_set,
    input  logic [ARGS_MAX-1:0][DATA_WIDTH-1:0] live,
    input  logic [SW-1:0]                      rd_set,
    input  logic [IW-1:0]                      rd_idx,
    output logic [DATA_WIDTH-1:0]              rd_data
);

    logic [SETS-1:0][ARGS_MAX-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (copy_en) mem_d[copy_set] = live;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_set][rd_idx];

endmodule

// File: rtl/diagnosis_stackargs_snapshot.sv
// Stack-argument snapshot unit: captures l.sw to SP-relative slots from the delayed
// trace, snapshots them per event and streams typed flits. Option: DIAGNOSIS_STACKARGS_DROPCNT_EN.
module diagnosis_stackargs_snapshot
    import diagnosis_stackargs_snapshot_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ARGS_MAX   = 8,
    parameter int SETS       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int SNAP_DELAY = 2,
    parameter int SP_REG     = 1
) (
    input  logic clk,
    input  logic rst,
    diagnosis_stackargs_snapshot_if.slave bus
);

    localparam int SW  = $clog2(SETS);
    localparam int IW  = (ARGS_MAX > 1) ? $clog2(ARGS_MAX) : 1;
    localparam int OW  = $clog2(SETS + 1);
    localparam int FW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    logic [SNAP_DELAY-1:0][32:0]          dly_q, dly_d;
    logic [ARGS_MAX-1:0][DATA_WIDTH-1:0]  live_q, live_d;
    evt_t [FIFO_DEPTH-1:0]                fifo_q, fifo_d;
    logic [FW-1:0]                        fwp_q, fwp_d, frp_q, frp_d;
    logic [FCW-1:0]                       fcnt_q, fcnt_d;
    logic [SW-1:0]                        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]                        occ_q, occ_d;
    rd_state_e                            state_q, state_d;
    logic [5:0]                           cnt_q, cnt_d, idx_q, idx_d;
    logic                                 out_valid_q, out_valid_d;
    flit_type_e                           out_type_q, out_type_d;
    logic [DATA_WIDTH-1:0]                out_data_q, out_data_d, none_data, rd_data;
    logic [IW-1:0]                        rd_idx;
`ifdef DIAGNOSIS_STACKARGS_DROPCNT_EN
    logic                                 drop_q, drop_d;
    logic [15:0]                          drop_cnt_q, drop_cnt_d;
`endif

    logic [31:0] d_insn;
    logic [15:0] d_imm;
    logic        d_en, cap, push, pop, alloc, free, last;
    logic [5:0]  args_eff;
    evt_t        evt_in, head;

    // Trace delay line aligns the store with the GPR read of its rB.
    always_comb begin
        dly_d[0] = {bus.trace_enable, bus.trace_insn};
        for (int i = 1; i < SNAP_DELAY; i++) dly_d[i] = dly_q[i-1];
    end

    assign d_en           = dly_q[SNAP_DELAY-1][32];
    assign d_insn         = dly_q[SNAP_DELAY-1][31:0];
    assign d_imm          = {d_insn[25:21], d_insn[10:0]};
    assign bus.gpr_addr_o = d_insn[15:11];

    assign cap = d_en && (d_insn[31:26] == OPC_LSW) && (d_insn[20:16] == 5'(SP_REG)) &&
                 !d_imm[10] && (d_imm[1:0] == 2'b00) && (d_imm[15:2] < 14'(ARGS_MAX));

    always_comb begin
        live_d = live_q;
        if (cap) live_d[d_imm[IW+1:2]] = bus.gpr_data_i;
    end

    // Event intake; occupancy is checked against the registered value, so a set
    // freed this cycle only becomes allocatable next cycle.
    assign args_eff       = (bus.args_in > 6'(ARGS_MAX)) ? 6'(ARGS_MAX) : bus.args_in;
    assign bus.args_ready = (fcnt_q != FCW'(FIFO_DEPTH));
    assign push           = bus.args_valid && bus.args_ready;
    assign alloc          = push && (args_eff != 6'd0) && (occ_q < OW'(SETS));
    assign evt_in.drop    = (args_eff != 6'd0) && (occ_q == OW'(SETS));
    assign evt_in.n       = args_eff;
    assign head           = fifo_q[frp_q];
    assign pop            = (state_q == ST_IDLE) && (fcnt_q != '0);

    always_comb begin
        fifo_d   = fifo_q;
        fwp_d    = fwp_q;
        frp_d    = frp_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            fifo_d[fwp_q] = evt_in;
            fwp_d = (fwp_q == FW'(FIFO_DEPTH-1)) ? '0 : fwp_q + 1'b1;
        end
        if (pop)   frp_d    = (frp_q == FW'(FIFO_DEPTH-1)) ? '0 : frp_q + 1'b1;
        if (alloc) wr_ptr_d = (wr_ptr_q == SW'(SETS-1)) ? '0 : wr_ptr_q + 1'b1;
        fcnt_d = fcnt_q + FCW'(push) - FCW'(pop);
        occ_d  = occ_q + OW'(alloc) - OW'(free);
    end

`ifdef DIAGNOSIS_STACKARGS_DROPCNT_EN
    assign drop_cnt_d     = (push && evt_in.drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    assign none_data      = drop_q ? DATA_WIDTH'(drop_cnt_q) : '0;
    assign bus.drop_cnt_o = drop_cnt_q;
`else
    assign none_data = '0;
`endif

    assign last   = (cnt_q == 6'd0) || (idx_q == cnt_q - 6'd1);
    assign free   = (state_q == ST_SEND) && bus.out_ready && last && (cnt_q != 6'd0);
    assign rd_idx = (state_q == ST_LOAD) ? '0 : IW'(idx_q + 6'd1);

    diagnosis_stackargs_setbuf #(.DATA_WIDTH(DATA_WIDTH), .ARGS_MAX(ARGS_MAX), .SETS(SETS)) u_setbuf (
        .clk(clk), .rst(rst), .copy_en(alloc), .copy_set(wr_ptr_q), .live(live_q),
        .rd_set(rd_ptr_q), .rd_idx(rd_idx), .rd_data(rd_data)
    );

    // Read FSM; outputs only change on LOAD or on a transfer, so they hold under stall.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_type_d  = out_type_q;
        out_data_d  = out_data_q;
`ifdef DIAGNOSIS_STACKARGS_DROPCNT_EN
        drop_d      = drop_q;
`endif
        case (state_q)
            ST_IDLE: if (pop) begin
                state_d = ST_LOAD;
                cnt_d   = head.drop ? 6'd0 : head.n;
                idx_d   = 6'd0;
`ifdef DIAGNOSIS_STACKARGS_DROPCNT_EN
                drop_d  = head.drop;
`endif
            end
            ST_LOAD: begin
                state_d     = ST_SEND;
                out_valid_d = 1'b1;
                out_type_d  = flit_type(cnt_q, 6'd0);
                out_data_d  = (cnt_q == 6'd0) ? none_data : rd_data;
            end
            default: if (bus.out_ready) begin
                if (last) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_type_d  = SNAPSHOT_FLIT_TYPE_NONE;
                    out_data_d  = '0;
                    if (free) rd_ptr_d = (rd_ptr_q == SW'(SETS-1)) ? '0 : rd_ptr_q + 1'b1;
                end else begin
                    idx_d      = idx_q + 6'd1;
                    out_type_d = flit_type(cnt_q, idx_q + 6'd1);
                    out_data_d = rd_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q <= '0;  live_q <= '0;  fifo_q <= '0;
            fwp_q <= '0;  frp_q <= '0;   fcnt_q <= '0;
            wr_ptr_q <= '0; rd_ptr_q <= '0; occ_q <= '0;
            state_q <= ST_IDLE; cnt_q <= '0; idx_q <= '0;
            out_valid_q <= 1'b0; out_type_q <= SNAPSHOT_FLIT_TYPE_NONE; out_data_q <= '0;
`ifdef DIAGNOSIS_STACKARGS_DROPCNT_EN
            drop_q <= 1'b0; drop_cnt_q <= '0;
`endif
        end else begin
            dly_q <= dly_d;  live_q <= live_d;  fifo_q <= fifo_d;
            fwp_q <= fwp_d;  frp_q <= frp_d;    fcnt_q <= fcnt_d;
            wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; occ_q <= occ_d;
            state_q <= state_d; cnt_q <= cnt_d; idx_q <= idx_d;
            out_valid_q <= out_valid_d; out_type_q <= out_type_d; out_data_q <= out_data_d;
`ifdef DIAGNOSIS_STACKARGS_DROPCNT_EN
            drop_q <= drop_d; drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_type  = out_type_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_diagnosis_stackargs_snapshot.sv
// Directed bench for diagnosis_stackargs_snapshot (ARGS_MAX=8, SETS=4, SNAP_DELAY=2, SP=r1).
// Honours DIAGNOSIS_STACKARGS_DROPCNT_EN for the drop counter checks.
module tb_diagnosis_stackargs_snapshot;
    import diagnosis_stackargs_snapshot_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    diagnosis_stackargs_snapshot_if #(.DATA_WIDTH(DW)) bus();

    diagnosis_stackargs_snapshot #(
        .DATA_WIDTH(DW), .ARGS_MAX(8), .SETS(4), .FIFO_DEPTH(4), .SNAP_DELAY(2), .SP_REG(1)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] gpr [32];
    assign bus.gpr_data_i = gpr[bus.gpr_addr_o];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lsw(input logic [15:0] off, input logic [4:0] ra, input logic [4:0] rb);
        return {6'b110101, off[15:11], ra, rb, off[10:0]};
    endfunction

    task automatic store(input logic [15:0] off, input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clk); #1;
        bus.trace_insn = lsw(off, ra, rb);
        bus.trace_enable = 1'b1;
        @(posedge clk); #1;
        bus.trace_enable = 1'b0;
        bus.trace_insn = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic evt(input logic [5:0] n);
        @(posedge clk); #1;
        bus.args_in = n;
        bus.args_valid = 1'b1;
        @(posedge clk); #1;
        bus.args_valid = 1'b0;
    endtask

    // Waits (bounded) for a valid flit at a negedge and checks it; out_ready=1 advances one flit per call.
    task automatic exp_flit(input string tag, input flit_type_e t, input logic [31:0] d);
        int i;
        i = 0;
        @(negedge clk);
        while (!bus.out_valid && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_v"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_t"}, 64'(bus.out_type), 64'(t));
        chk({tag, "_d"}, 64'(bus.out_data), 64'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   got_d [3];
        flit_type_e    got_t [3];
        int            ngot;
        logic          was_stall;
        logic [31:0]   prev_d;
        flit_type_e    prev_t;
        int            i;

        for (int r = 0; r < 32; r++) gpr[r] = '0;
        bus.trace_insn = '0; bus.trace_enable = 1'b0;
        bus.args_in = '0; bus.args_valid = 1'b0; bus.out_ready = 1'b1;

        // reset state
        #12;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_type",  64'(bus.out_type), 64'(SNAPSHOT_FLIT_TYPE_NONE));
        chk("rst_data",  64'(bus.out_data), 64'd0);
        chk("rst_ready", 64'(bus.args_ready), 64'd1);
`ifdef DIAGNOSIS_STACKARGS_DROPCNT_EN
        chk("rst_dropcnt", 64'(bus.drop_cnt_o), 64'd0);
`endif
        @(posedge clk); #1 rst = 1'b0;

        // 1: three stores then a 3-arg event, with latency check
        gpr[3] = 32'h11; gpr[4] = 32'h22; gpr[5] = 32'h33; gpr[6] = 32'h77;
        store(16'd0, 5'd1, 5'd3);
        store(16'd4, 5'd1, 5'd4);
        store(16'd8, 5'd1, 5'd5);
        store(16'd28, 5'd1, 5'd6);
        evt(6'd3);
        @(negedge clk); chk("t1_lat0", 64'(bus.out_valid), 64'd0);
        @(negedge clk); chk("t1_lat1", 64'(bus.out_valid), 64'd0);
        @(negedge clk); chk("t1_lat2", 64'(bus.out_valid), 64'd1);
        chk("t1_first_t", 64'(bus.out_type), 64'(SNAPSHOT_FLIT_TYPE_FIRST));
        chk("t1_first_d", 64'(bus.out_data), 64'h11);
        exp_flit("t1_mid",  SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h22);
        exp_flit("t1_last", SNAPSHOT_FLIT_TYPE_LAST,   32'h33);
        @(negedge clk); chk("t1_done", 64'(bus.out_valid), 64'd0);

        // 2: single, zero-arg and clamped events
        evt(6'd1);
        exp_flit("t2_single", SNAPSHOT_FLIT_TYPE_SINGLE, 32'h11);
        evt(6'd0);
        exp_flit("t2_none", SNAPSHOT_FLIT_TYPE_NONE, 32'h0);
        evt(6'd40);
        exp_flit("t2_c0", SNAPSHOT_FLIT_TYPE_FIRST,  32'h11);
        exp_flit("t2_c1", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h22);
        exp_flit("t2_c2", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h33);
        exp_flit("t2_c3", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h0);
        exp_flit("t2_c4", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h0);
        exp_flit("t2_c5", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h0);
        exp_flit("t2_c6", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h0);
        exp_flit("t2_c7", SNAPSHOT_FLIT_TYPE_LAST,   32'h77);
        @(negedge clk); chk("t2_done", 64'(bus.out_valid), 64'd0);

        // 3: stalled sink, SETS+1 events with a distinct arg0 each -> 4 snapshots + 1 drop
        @(posedge clk); #1 bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            gpr[8+k] = 32'hA0 + 32'(k);
            store(16'd0, 5'd1, 5'(8+k));
            evt(6'd2);
        end
        @(negedge clk);
        chk("t3_full", 64'(bus.args_ready), 64'd0);
        chk("t3_stall_t", 64'(bus.out_type), 64'(SNAPSHOT_FLIT_TYPE_FIRST));
        chk("t3_stall_d", 64'(bus.out_data), 64'hA0);
        repeat (3) @(negedge clk);
        chk("t3_hold_t", 64'(bus.out_type), 64'(SNAPSHOT_FLIT_TYPE_FIRST));
        chk("t3_hold_d", 64'(bus.out_data), 64'hA0);
`ifdef DIAGNOSIS_STACKARGS_DROPCNT_EN
        chk("t3_dropcnt", 64'(bus.drop_cnt_o), 64'd1);
`endif
        @(posedge clk); #1 bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_flit($sformatf("t3_s%0d_f", k), SNAPSHOT_FLIT_TYPE_FIRST, 32'hA0 + 32'(k));
            exp_flit($sformatf("t3_s%0d_l", k), SNAPSHOT_FLIT_TYPE_LAST,  32'h22);
        end
`ifdef DIAGNOSIS_STACKARGS_DROPCNT_EN
        exp_flit("t3_drop", SNAPSHOT_FLIT_TYPE_NONE, 32'h1);
`else
        exp_flit("t3_drop", SNAPSHOT_FLIT_TYPE_NONE, 32'h0);
`endif
        @(negedge clk); chk("t3_ready_back", 64'(bus.args_ready), 64'd1);

        // 4: out_ready toggles every cycle; stalled outputs must hold
        @(posedge clk); #1 bus.out_ready = 1'b0;
        evt(6'd3);
        ngot = 0; was_stall = 1'b0; prev_d = '0; prev_t = SNAPSHOT_FLIT_TYPE_NONE; i = 0;
        while (ngot < 3 && i < 40) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (was_stall) begin
                    chk("t4_hold_t", 64'(bus.out_type), 64'(prev_t));
                    chk("t4_hold_d", 64'(bus.out_data), 64'(prev_d));
                end
                if (bus.out_ready) begin
                    got_t[ngot] = bus.out_type;
                    got_d[ngot] = bus.out_data;
                    ngot++;
                end
                was_stall = !bus.out_ready;
                prev_t = bus.out_type;
                prev_d = bus.out_data;
            end else was_stall = 1'b0;
            @(posedge clk); #1 bus.out_ready = ~bus.out_ready;
            i++;
        end
        bus.out_ready = 1'b1;
        chk("t4_n", 64'(ngot), 64'd3);
        if (ngot == 3) begin
            chk("t4_0t", 64'(got_t[0]), 64'(SNAPSHOT_FLIT_TYPE_FIRST));
            chk("t4_0d", 64'(got_d[0]), 64'hA4);
            chk("t4_1t", 64'(got_t[1]), 64'(SNAPSHOT_FLIT_TYPE_MIDDLE));
            chk("t4_1d", 64'(got_d[1]), 64'h22);
            chk("t4_2t", 64'(got_t[2]), 64'(SNAPSHOT_FLIT_TYPE_LAST));
            chk("t4_2d", 64'(got_d[2]), 64'h33);
        end
        @(negedge clk); @(negedge clk);
        chk("t4_done", 64'(bus.out_valid), 64'd0);

        // 5: stores that must be ignored leave the live buffer intact
        gpr[20] = 32'hDEAD0001; gpr[21] = 32'hDEAD0002; gpr[22] = 32'hDEAD0003; gpr[23] = 32'hDEAD0004;
        store(16'hFFFC, 5'd1, 5'd20);
        store(16'd2,    5'd1, 5'd21);
        store(16'd32,   5'd1, 5'd22);
        store(16'd0,    5'd2, 5'd23);
        evt(6'd8);
        exp_flit("t5_0", SNAPSHOT_FLIT_TYPE_FIRST,  32'hA4);
        exp_flit("t5_1", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h22);
        exp_flit("t5_2", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h33);
        exp_flit("t5_3", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h0);
        exp_flit("t5_4", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h0);
        exp_flit("t5_5", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h0);
        exp_flit("t5_6", SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h0);
        exp_flit("t5_7", SNAPSHOT_FLIT_TYPE_LAST,   32'h77);

        // 6: reset while the second flit is presented
        @(posedge clk); #1 bus.out_ready = 1'b0;
        evt(6'd3);
        i = 0;
        @(negedge clk);
        while (!bus.out_valid && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("t6_first_t", 64'(bus.out_type), 64'(SNAPSHOT_FLIT_TYPE_FIRST));
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t6_mid_t", 64'(bus.out_type), 64'(SNAPSHOT_FLIT_TYPE_MIDDLE));
        chk("t6_mid_d", 64'(bus.out_data), 64'h22);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_type",  64'(bus.out_type), 64'(SNAPSHOT_FLIT_TYPE_NONE));
        chk("t6_rst_ready", 64'(bus.args_ready), 64'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        gpr[24] = 32'h55;
        store(16'd0, 5'd1, 5'd24);
        evt(6'd1);
        exp_flit("t6_single", SNAPSHOT_FLIT_TYPE_SINGLE, 32'h55);
        evt(6'd2);
        exp_flit("t6_f", SNAPSHOT_FLIT_TYPE_FIRST, 32'h55);
        exp_flit("t6_l", SNAPSHOT_FLIT_TYPE_LAST,  32'h0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
